board_manager: RTL and testbench

- Downstream stage of the game controller. Holds the 3x3 tic-tac-toe board and commits moves on pos/w_e/player.
- Returns the occupancy of the addressed cell to the controller's busy check.
- Runs a sequential 8-line win scan after every committed move and reports win/full back to the controller FSM.
- Exports the packed board for the display path.

---
 rtl/board_pkg.sv | 31 +++
 rtl/board_manager_line_check.sv | 17 +
 rtl/board_manager.sv | 104 ++++++++++
 tb/tb_board_manager.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared types and the winning-line table for the tic-tac-toe board manager.
package board_pkg;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } scan_state_t;

  // Cell triples for rows, columns, then the two diagonals.
  localparam logic [3:0] LINES [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/board_manager_line_check.sv
// Combinational test of one winning line: three equal, non-empty marks.
import board_pkg::*;

module line_check (
  input  cell_t a,
  input  cell_t b,
  input  cell_t c,
  output logic  match,
  output cell_t mark
);

  always_comb begin
    match = (a != EMPTY) && (a == b) && (b == c);
    mark  = match ? a : EMPTY;
  end

endmodule

// File: rtl/board_manager.sv
// Holds the 3x3 board, qualifies writes and runs a one-line-per-cycle win scan
// after every committed move.
import board_pkg::*;

module board_manager (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_e,
  input  logic [3:0]  pos,
  input  logic [1:0]  player,
  output logic [1:0]  state,
  output logic        win,
  output logic        full,
  output logic [1:0]  winner,
  output logic        scan_busy,
  output logic [17:0] board
);

  cell_t       cells [NUM_CELLS];
  scan_state_t state_q, state_d;
  logic [3:0]  move_cnt;
  logic [2:0]  line_idx;
  logic        hit;
  cell_t       hit_mark;
  logic        line_match;
  cell_t       line_mark;
  logic        accept;

  // Out-of-range positions read as 11 so the controller treats them as busy.
  always_comb begin
    state = 2'b11;
    if (pos <= 4'd8) state = cells[pos];
  end

  always_comb begin
    board = '0;
    for (int i = 0; i < NUM_CELLS; i++) board[2*i +: 2] = cells[i];
  end

  assign accept = w_e && (state_q == IDLE) && (state == 2'b00) &&
                  ((player == 2'b01) || (player == 2'b10)) && !win && !full;

  line_check u_line_check (
    .a     (cells[LINES[line_idx][0]]),
    .b     (cells[LINES[line_idx][1]]),
    .c     (cells[LINES[line_idx][2]]),
    .match (line_match),
    .mark  (line_mark)
  );

  always_comb begin
    state_d   = state_q;
    scan_busy = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = SCAN;
      SCAN: begin
        scan_busy = 1'b1;
        if (line_idx == 3'd7) state_d = DONE;
      end
      DONE: begin
        scan_busy = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CELLS; i++) cells[i] <= EMPTY;
      state_q  <= IDLE;
      move_cnt <= 4'd0;
      line_idx <= 3'd0;
      hit      <= 1'b0;
      hit_mark <= EMPTY;
      win      <= 1'b0;
      full     <= 1'b0;
      winner   <= 2'b00;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cells[pos] <= cell_t'(player);
        move_cnt   <= move_cnt + 4'd1;
        line_idx   <= 3'd0;
      end
      // Only the first matching line is kept as the result.
      if (state_q == SCAN) begin
        if (line_match && !hit) begin
          hit      <= 1'b1;
          hit_mark <= line_mark;
        end
        line_idx <= line_idx + 3'd1;
      end
      if (state_q == DONE) begin
        win      <= hit;
        winner   <= hit_mark;
        full     <= (move_cnt == 4'd9) && !hit;
        hit      <= 1'b0;
        hit_mark <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_board_manager.sv
// Directed self-checking bench for board_manager: one task per scenario.
module tb_board_manager;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        w_e = 1'b0;
  logic [3:0]  pos = 4'd0;
  logic [1:0]  player = 2'b00;
  logic [1:0]  state;
  logic        win, full, scan_busy;
  logic [1:0]  winner;
  logic [17:0] board;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  board_manager dut (
    .clk       (clk),
    .rst       (rst),
    .w_e       (w_e),
    .pos       (pos),
    .player    (player),
    .state     (state),
    .win       (win),
    .full      (full),
    .winner    (winner),
    .scan_busy (scan_busy),
    .board     (board)
  );

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Presents a write for exactly one rising edge; returns at the following negedge.
  task automatic do_write(input logic [3:0] p, input logic [1:0] pl);
    @(negedge clk); w_e = 1'b1; pos = p; player = pl;
    @(negedge clk); w_e = 1'b0;
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (board !== 18'h0) begin bad++; $display("[TB] FAIL reset_board: got %h expected %h", board, 18'h0); end
    total++; if (win !== 1'b0) begin bad++; $display("[TB] FAIL reset_win: got %b expected 0", win); end
    total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    total++; if (scan_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", scan_busy); end
    total++; if (winner !== 2'b00) begin bad++; $display("[TB] FAIL reset_winner: got %b expected 00", winner); end
    for (int i = 0; i < 9; i++) begin
      pos = 4'(i); #1;
      total++; if (state !== 2'b00) begin bad++; $display("[TB] FAIL reset_state pos %0d: got %b expected 00", i, state); end
    end
    pos = 4'd12; #1;
    total++; if (state !== 2'b11) begin bad++; $display("[TB] FAIL state_pos12: got %b expected 11", state); end
  endtask

  task automatic test_single_write();
    int busy_cnt;
    do_reset();
    do_write(4'd4, 2'b01);
    total++; if (state !== 2'b01) begin bad++; $display("[TB] FAIL write_state: got %b expected 01", state); end
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (scan_busy) busy_cnt++;
      @(negedge clk);
    end
    total++; if (busy_cnt !== 9) begin bad++; $display("[TB] FAIL busy_cycles: got %0d expected 9", busy_cnt); end
    total++; if (scan_busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_after: got %b expected 0", scan_busy); end
    total++; if (win !== 1'b0) begin bad++; $display("[TB] FAIL single_win: got %b expected 0", win); end
    total++; if (board[9:8] !== 2'b01) begin bad++; $display("[TB] FAIL board_cell4: got %b expected 01", board[9:8]); end
  endtask

  task automatic test_win();
    do_reset();
    do_write(4'd0, 2'b01); settle();
    do_write(4'd1, 2'b10); settle();
    do_write(4'd4, 2'b01); settle();
    do_write(4'd2, 2'b10); settle();
    do_write(4'd8, 2'b01);
    repeat (8) @(negedge clk);
    total++; if (win !== 1'b0) begin bad++; $display("[TB] FAIL win_early: got %b expected 0", win); end
    total++; if (scan_busy !== 1'b1) begin bad++; $display("[TB] FAIL busy_in_done: got %b expected 1", scan_busy); end
    @(negedge clk);
    total++; if (win !== 1'b1) begin bad++; $display("[TB] FAIL win_set: got %b expected 1", win); end
    total++; if (winner !== 2'b01) begin bad++; $display("[TB] FAIL winner_p1: got %b expected 01", winner); end
    total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL win_full: got %b expected 0", full); end
    total++; if (scan_busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_fall: got %b expected 0", scan_busy); end
    do_write(4'd3, 2'b10); settle();
    total++; if (board !== 18'h10129) begin bad++; $display("[TB] FAIL frozen_board: got %h expected %h", board, 18'h10129); end
    pos = 4'd3; #1;
    total++; if (state !== 2'b00) begin bad++; $display("[TB] FAIL frozen_cell3: got %b expected 00", state); end
  endtask

  task automatic test_rejects();
    do_reset();
    do_write(4'd0, 2'b01); settle();
    do_write(4'd0, 2'b10);
    total++; if (scan_busy !== 1'b0) begin bad++; $display("[TB] FAIL occupied_busy: got %b expected 0", scan_busy); end
    total++; if (board !== 18'h00001) begin bad++; $display("[TB] FAIL occupied_board: got %h expected %h", board, 18'h00001); end
    do_write(4'd9, 2'b01);
    total++; if (scan_busy !== 1'b0) begin bad++; $display("[TB] FAIL pos9_busy: got %b expected 0", scan_busy); end
    total++; if (state !== 2'b11) begin bad++; $display("[TB] FAIL pos9_state: got %b expected 11", state); end
    total++; if (board !== 18'h00001) begin bad++; $display("[TB] FAIL pos9_board: got %h expected %h", board, 18'h00001); end
    do_write(4'd5, 2'b00);
    total++; if (scan_busy !== 1'b0) begin bad++; $display("[TB] FAIL player0_busy: got %b expected 0", scan_busy); end
    total++; if (board !== 18'h00001) begin bad++; $display("[TB] FAIL player0_board: got %h expected %h", board, 18'h00001); end
    do_write(4'd1, 2'b10);
    repeat (2) @(negedge clk);
    do_write(4'd2, 2'b01);
    total++; if (state !== 2'b00) begin bad++; $display("[TB] FAIL midscan_cell2: got %b expected 00", state); end
    settle();
    total++; if (board !== 18'h00009) begin bad++; $display("[TB] FAIL midscan_board: got %h expected %h", board, 18'h00009); end
    total++; if (scan_busy !== 1'b0) begin bad++; $display("[TB] FAIL midscan_idle: got %b expected 0", scan_busy); end
  endtask

  task automatic test_draw();
    logic [3:0] seq_pos [9];
    logic [1:0] seq_pl  [9];
    seq_pos = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
    seq_pl  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_write(seq_pos[i], seq_pl[i]); settle();
    end
    total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL draw_full_early: got %b expected 0", full); end
    do_write(seq_pos[8], seq_pl[8]); settle();
    total++; if (full !== 1'b1) begin bad++; $display("[TB] FAIL draw_full: got %b expected 1", full); end
    total++; if (win !== 1'b0) begin bad++; $display("[TB] FAIL draw_win: got %b expected 0", win); end
    total++; if (winner !== 2'b00) begin bad++; $display("[TB] FAIL draw_winner: got %b expected 00", winner); end
    total++; if (board !== 18'h16A59) begin bad++; $display("[TB] FAIL draw_board: got %h expected %h", board, 18'h16A59); end
  endtask

  task automatic test_ninth_win();
    logic [3:0] seq_pos [9];
    logic [1:0] seq_pl  [9];
    seq_pos = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd8, 4'd6, 4'd7};
    seq_pl  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_write(seq_pos[i], seq_pl[i]); settle();
    end
    total++; if (win !== 1'b0) begin bad++; $display("[TB] FAIL ninth_win_early: got %b expected 0", win); end
    do_write(seq_pos[8], seq_pl[8]); settle();
    total++; if (win !== 1'b1) begin bad++; $display("[TB] FAIL ninth_win: got %b expected 1", win); end
    total++; if (winner !== 2'b10) begin bad++; $display("[TB] FAIL ninth_winner: got %b expected 10", winner); end
    total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL ninth_full: got %b expected 0", full); end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    do_write(4'd0, 2'b01); settle();
    do_write(4'd1, 2'b01); settle();
    do_write(4'd2, 2'b01);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (board !== 18'h0) begin bad++; $display("[TB] FAIL rstscan_board: got %h expected %h", board, 18'h0); end
    total++; if (scan_busy !== 1'b0) begin bad++; $display("[TB] FAIL rstscan_busy: got %b expected 0", scan_busy); end
    repeat (12) @(negedge clk);
    total++; if (win !== 1'b0) begin bad++; $display("[TB] FAIL rstscan_win: got %b expected 0", win); end
    total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL rstscan_full: got %b expected 0", full); end
    total++; if (winner !== 2'b00) begin bad++; $display("[TB] FAIL rstscan_winner: got %b expected 00", winner); end
    do_write(4'd4, 2'b10);
    total++; if (state !== 2'b10) begin bad++; $display("[TB] FAIL rstscan_rewrite: got %b expected 10", state); end
    total++; if (scan_busy !== 1'b1) begin bad++; $display("[TB] FAIL rstscan_rescan: got %b expected 1", scan_busy); end
    settle();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_win();
    test_rejects();
    test_draw();
    test_ninth_win();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
